// File: rtl/snes_bus_sync.sv
// SNES cartridge-bus front end: synchronise, glitch-filter strobes, track the access FSM and
// hold the address stable for the decoder. Optional strobe filter enabled by SNES_BUS_FILTER_EN.
//
// state | meaning
// IDLE  | no access; address outputs track the synchronised bus
// RD    | read access active (/RD filtered low); address frozen
// WR    | write access active (/WR filtered low); address frozen
module snes_bus_sync #(
  parameter int ADDR_W       = 24,
  parameter int PA_W         = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_DEPTH = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] SNES_ADDR_IN,
  input  logic [PA_W-1:0]   SNES_PA_IN,
  input  logic              SNES_ROMSEL_IN,
  input  logic              SNES_READ_IN,
  input  logic              SNES_WRITE_IN,
  input  logic              SNES_PARD_IN,
  input  logic              SNES_PAWR_IN,
  output logic [ADDR_W-1:0] SNES_ADDR,
  output logic [PA_W-1:0]   SNES_PA,
  output logic              SNES_ROMSEL,
  output logic              SNES_RD_START,
  output logic              SNES_RD_END,
  output logic              SNES_WR_START,
  output logic              SNES_WR_END,
  output logic              SNES_PARD_START,
  output logic              SNES_PAWR_START,
  output logic              BUS_BUSY,
  output logic              BUS_CONFLICT
);

  localparam int NS     = 4;
  localparam int I_RD   = 0;
  localparam int I_WR   = 1;
  localparam int I_PARD = 2;
  localparam int I_PAWR = 3;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("snes_bus_sync: SYNC_STAGES must be 2..4");
  end
  if (FILTER_DEPTH < 1 || FILTER_DEPTH > 8) begin : g_bad_filt
    $error("snes_bus_sync: FILTER_DEPTH must be 1..8");
  end

  logic [NS-1:0] strb_raw;
  assign strb_raw = {SNES_PAWR_IN, SNES_PARD_IN, SNES_WRITE_IN, SNES_READ_IN};

  logic [SYNC_STAGES-1:0][NS-1:0]     strb_sync;
  logic [SYNC_STAGES-1:0][ADDR_W-1:0] addr_sync;
  logic [SYNC_STAGES-1:0][PA_W-1:0]   pa_sync;
  logic [SYNC_STAGES-1:0]             romsel_sync;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      strb_sync   <= '1;
      addr_sync   <= '0;
      pa_sync     <= '0;
      romsel_sync <= '1;
    end else begin
      strb_sync   <= {strb_sync[SYNC_STAGES-2:0], strb_raw};
      addr_sync   <= {addr_sync[SYNC_STAGES-2:0], SNES_ADDR_IN};
      pa_sync     <= {pa_sync[SYNC_STAGES-2:0], SNES_PA_IN};
      romsel_sync <= {romsel_sync[SYNC_STAGES-2:0], SNES_ROMSEL_IN};
    end
  end

  logic [NS-1:0]     strb_s;
  logic [ADDR_W-1:0] addr_s;
  logic [PA_W-1:0]   pa_s;
  logic              romsel_s;
  assign strb_s   = strb_sync[SYNC_STAGES-1];
  assign addr_s   = addr_sync[SYNC_STAGES-1];
  assign pa_s     = pa_sync[SYNC_STAGES-1];
  assign romsel_s = romsel_sync[SYNC_STAGES-1];

  // all_lo/all_hi: the sample window unanimously agrees on a level
  logic [NS-1:0] all_lo;
  logic [NS-1:0] all_hi;

`ifdef SNES_BUS_FILTER_EN
  // The last synchroniser stage is the newest window bit, so only FILTER_DEPTH-1 extra flops.
  for (genvar s = 0; s < NS; s++) begin : g_filt
    logic [FILTER_DEPTH-1:0] win;
    if (FILTER_DEPTH > 1) begin : g_hist
      logic [FILTER_DEPTH-2:0] hist;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) hist <= '1;
        else        hist <= win[FILTER_DEPTH-2:0];
      end
      assign win = {hist, strb_s[s]};
    end else begin : g_one
      assign win = strb_s[s];
    end
    assign all_lo[s] = ~|win;
    assign all_hi[s] = &win;
  end
`else
  assign all_lo = ~strb_s;
  assign all_hi = strb_s;
`endif

  logic [NS-1:0] lvl;
  logic [NS-1:0] fall;
  logic [1:0]    rise;
  assign fall = lvl & all_lo;
  assign rise = ~lvl[1:0] & all_hi[1:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) lvl <= '1;
    else        lvl <= (lvl & ~all_lo) | all_hi;
  end

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state;
  logic   wr_block;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state           <= IDLE;
      wr_block        <= 1'b0;
      SNES_ADDR       <= '0;
      SNES_PA         <= '0;
      SNES_ROMSEL     <= 1'b1;
      SNES_RD_START   <= 1'b0;
      SNES_RD_END     <= 1'b0;
      SNES_WR_START   <= 1'b0;
      SNES_WR_END     <= 1'b0;
      SNES_PARD_START <= 1'b0;
      SNES_PAWR_START <= 1'b0;
      BUS_BUSY        <= 1'b0;
      BUS_CONFLICT    <= 1'b0;
    end else begin
      SNES_RD_START   <= 1'b0;
      SNES_RD_END     <= 1'b0;
      SNES_WR_START   <= 1'b0;
      SNES_WR_END     <= 1'b0;
      SNES_PARD_START <= fall[I_PARD];
      SNES_PAWR_START <= fall[I_PAWR];
      unique case (state)
        IDLE: begin
          SNES_ADDR   <= addr_s;
          SNES_PA     <= pa_s;
          SNES_ROMSEL <= romsel_s;
          if (lvl[I_WR]) wr_block <= 1'b0;
          if (fall[I_RD]) begin
            state         <= RD;
            SNES_RD_START <= 1'b1;
            BUS_BUSY      <= 1'b1;
            // a write strobe arriving alongside the read is locked out until it is seen high again
            if (fall[I_WR]) begin
              BUS_CONFLICT <= 1'b1;
              wr_block     <= 1'b1;
            end
          end else if (fall[I_WR] && !wr_block) begin
            state         <= WR;
            SNES_WR_START <= 1'b1;
            BUS_BUSY      <= 1'b1;
          end
        end
        RD: begin
          if (fall[I_WR]) BUS_CONFLICT <= 1'b1;
          if (rise[I_RD]) begin
            state       <= IDLE;
            SNES_RD_END <= 1'b1;
            BUS_BUSY    <= 1'b0;
          end
        end
        WR: begin
          if (fall[I_RD]) BUS_CONFLICT <= 1'b1;
          if (rise[I_WR]) begin
            state       <= IDLE;
            SNES_WR_END <= 1'b1;
            BUS_BUSY    <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          BUS_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snes_bus_sync.sv
// Directed bench for snes_bus_sync; expected latencies follow the SNES_BUS_FILTER_EN build setting.
module tb_snes_bus_sync;

`ifdef SNES_BUS_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int LAT = FILT ? 5 : 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] addr_in;
  logic [7:0]  pa_in;
  logic        romsel_in, read_in, write_in, pard_in, pawr_in;
  logic [23:0] snes_addr;
  logic [7:0]  snes_pa;
  logic        snes_romsel, rd_start, rd_end, wr_start, wr_end;
  logic        pard_start, pawr_start, bus_busy, bus_conflict;

  int n_chk  = 0;
  int n_fail = 0;
  int c0, c1, first;

  snes_bus_sync dut (
    .CLK(clk), .RST_N(rst_n),
    .SNES_ADDR_IN(addr_in), .SNES_PA_IN(pa_in), .SNES_ROMSEL_IN(romsel_in),
    .SNES_READ_IN(read_in), .SNES_WRITE_IN(write_in),
    .SNES_PARD_IN(pard_in), .SNES_PAWR_IN(pawr_in),
    .SNES_ADDR(snes_addr), .SNES_PA(snes_pa), .SNES_ROMSEL(snes_romsel),
    .SNES_RD_START(rd_start), .SNES_RD_END(rd_end),
    .SNES_WR_START(wr_start), .SNES_WR_END(wr_end),
    .SNES_PARD_START(pard_start), .SNES_PAWR_START(pawr_start),
    .BUS_BUSY(bus_busy), .BUS_CONFLICT(bus_conflict)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; addr_in = 24'h00FFC0; pa_in = 8'h00; romsel_in = 1'b1;
    read_in = 1'b1; write_in = 1'b1; pard_in = 1'b1; pawr_in = 1'b1;
    #23;
    chk("rst_addr", {8'h0, snes_addr}, 32'h0);
    chk("rst_romsel", {31'h0, snes_romsel}, 32'h1);
    chk("rst_busy", {31'h0, bus_busy}, 32'h0);
    chk("rst_conflict", {31'h0, bus_conflict}, 32'h0);
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("pipe_addr_early", {8'h0, snes_addr}, 32'h0);
    step(1);
    chk("pipe_addr", {8'h0, snes_addr}, 32'h00FFC0);
    chk("pipe_pulses", {26'h0, rd_start, rd_end, wr_start, wr_end, pard_start, pawr_start}, 32'h0);
    chk("pipe_busy", {31'h0, bus_busy}, 32'h0);

    // read with address change mid-access
    addr_in = 24'hC01234; romsel_in = 1'b0;
    step(4);
    chk("idle_romsel", {31'h0, snes_romsel}, 32'h0);
    read_in = 1'b0;
    step(LAT - 1);
    chk("rd_start_early", {31'h0, rd_start}, 32'h0);
    step(1);
    chk("rd_start", {31'h0, rd_start}, 32'h1);
    chk("rd_busy", {31'h0, bus_busy}, 32'h1);
    chk("rd_addr_cap", {8'h0, snes_addr}, 32'hC01234);
    addr_in = 24'h7E0000; romsel_in = 1'b1;
    step(1);
    chk("rd_start_once", {31'h0, rd_start}, 32'h0);
    step(12 - (LAT + 1));
    read_in = 1'b1;
    chk("rd_addr_hold", {8'h0, snes_addr}, 32'hC01234);
    chk("rd_romsel_hold", {31'h0, snes_romsel}, 32'h0);
    step(LAT - 1);
    chk("rd_end_early", {31'h0, rd_end}, 32'h0);
    chk("rd_busy_late", {31'h0, bus_busy}, 32'h1);
    step(1);
    chk("rd_end", {31'h0, rd_end}, 32'h1);
    chk("rd_end_addr", {8'h0, snes_addr}, 32'hC01234);
    chk("rd_end_busy", {31'h0, bus_busy}, 32'h0);
    step(1);
    chk("rd_end_once", {31'h0, rd_end}, 32'h0);
    chk("track_addr", {8'h0, snes_addr}, 32'h7E0000);
    chk("track_romsel", {31'h0, snes_romsel}, 32'h1);

    // two-cycle /WR glitch
    step(3);
    write_in = 1'b0;
    c0 = 0; c1 = 0; first = -1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (i == 2) write_in = 1'b1;
      if (wr_start) begin
        c0++;
        if (first < 0) first = i;
      end
      if (wr_end) c1++;
    end
    chk("glitch_wr_start_cnt", c0, FILT ? 0 : 1);
    chk("glitch_wr_start_lat", first, FILT ? 32'hFFFFFFFF : 32'd3);
    chk("glitch_wr_end_cnt", c1, FILT ? 0 : 1);
    chk("glitch_busy", {31'h0, bus_busy}, 32'h0);
    chk("glitch_conflict", {31'h0, bus_conflict}, 32'h0);

    // /PARD in idle: one pulse, FSM untouched
    pard_in = 1'b0;
    c0 = 0; c1 = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (i == 6) pard_in = 1'b1;
      if (pard_start) c0++;
      if (bus_busy) c1++;
    end
    chk("pard_cnt", c0, 1);
    chk("pard_busy", c1, 0);

    // simultaneous /RD and /WR
    read_in = 1'b0; write_in = 1'b0;
    step(LAT);
    chk("sim_rd_start", {31'h0, rd_start}, 32'h1);
    chk("sim_wr_start", {31'h0, wr_start}, 32'h0);
    chk("sim_conflict", {31'h0, bus_conflict}, 32'h1);
    step(4);
    read_in = 1'b1; write_in = 1'b1;
    c0 = 0; c1 = 0;
    for (int i = 1; i <= LAT + 4; i++) begin
      step(1);
      if (rd_end) c0++;
      if (wr_end | wr_start) c1++;
    end
    chk("sim_rd_end_cnt", c0, 1);
    chk("sim_wr_pulse_cnt", c1, 0);
    chk("sim_conflict_sticky", {31'h0, bus_conflict}, 32'h1);
    chk("sim_busy", {31'h0, bus_busy}, 32'h0);

    // /PAWR during an active read
    pa_in = 8'h11;
    step(4);
    chk("pa_track", {24'h0, snes_pa}, 32'h11);
    read_in = 1'b0;
    step(LAT + 1);
    pa_in = 8'h3F; pawr_in = 1'b0;
    c0 = 0; c1 = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (i == 6) pawr_in = 1'b1;
      if (pawr_start) c0++;
      if (snes_pa !== 8'h11 || !bus_busy) c1++;
    end
    chk("pawr_cnt", c0, 1);
    chk("pawr_pa_frozen_busy", c1, 0);
    read_in = 1'b1;
    step(LAT);
    chk("pawr_rd_end", {31'h0, rd_end}, 32'h1);
    chk("pawr_pa_end", {24'h0, snes_pa}, 32'h11);
    step(1);
    chk("pawr_pa_after", {24'h0, snes_pa}, 32'h3F);

    // reset during a write
    addr_in = 24'h123456;
    step(4);
    write_in = 1'b0;
    step(LAT + 2);
    chk("wr_busy", {31'h0, bus_busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'h0, bus_busy}, 32'h0);
    chk("arst_conflict", {31'h0, bus_conflict}, 32'h0);
    chk("arst_addr", {8'h0, snes_addr}, 32'h0);
    chk("arst_romsel", {31'h0, snes_romsel}, 32'h1);
    chk("arst_wr_end", {31'h0, wr_end}, 32'h0);
    write_in = 1'b1;
    step(2);
    rst_n = 1'b1;
    c0 = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (wr_end | wr_start) c0++;
    end
    chk("post_rst_no_pulse", c0, 0);
    write_in = 1'b0;
    step(LAT);
    chk("post_wr_start", {31'h0, wr_start}, 32'h1);
    chk("post_wr_addr", {8'h0, snes_addr}, 32'h123456);
    write_in = 1'b1;
    step(LAT);
    chk("post_wr_end", {31'h0, wr_end}, 32'h1);
    chk("post_wr_busy", {31'h0, bus_busy}, 32'h0);
    chk("post_conflict", {31'h0, bus_conflict}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
